mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_req_slot.sv | 65 ++++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: the arbiter FSM state
// encoding, the request kind encoding, the port count and the grant-selection
// helper used by the arbiter.
package mem_arbiter_pkg;

  localparam int NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } req_kind_t;

  // Picks the winning port among the candidates. A lone candidate always wins.
  // On a tie, round-robin favours the port that did not win the previous tie;
  // fixed priority always favours port 0.
  function automatic logic pick_port(input logic [NPORTS-1:0] cand,
                                     input logic              last,
                                     input logic              rr);
    if (&cand) return rr ? ~last : 1'b0;
    return cand[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two request ports and the single-port RAM side of the arbiter.
//   p<i>_addr/wdata/wmask/rstrb : request from port i (wmask!=0 is a write
//                                 strobe, rstrb a one-cycle read strobe)
//   p<i>_rdata                  : registered read data for port i
//   p<i>_rbusy/wbusy            : read / write in progress on port i
//   mem_addr/wdata/wmask/rstrb  : command to the word RAM
//   mem_rdata                   : RAM read data, one cycle after mem_rstrb
// slave  : the arbiter's view; master : the requesters' and RAM's view.
interface mem_arbiter_if;

  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_wmask;
  logic        p0_rstrb;
  logic [31:0] p0_rdata;
  logic        p0_rbusy;
  logic        p0_wbusy;

  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_wmask;
  logic        p1_rstrb;
  logic [31:0] p1_rdata;
  logic        p1_rbusy;
  logic        p1_wbusy;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_addr, p0_wdata, p0_wmask, p0_rstrb,
    output p0_rdata, p0_rbusy, p0_wbusy,
    input  p1_addr, p1_wdata, p1_wmask, p1_rstrb,
    output p1_rdata, p1_rbusy, p1_wbusy,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata
  );

  modport master (
    output p0_addr, p0_wdata, p0_wmask, p0_rstrb,
    input  p0_rdata, p0_rbusy, p0_wbusy,
    output p1_addr, p1_wdata, p1_wmask, p1_rstrb,
    input  p1_rdata, p1_rbusy, p1_wbusy,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata
  );

endinterface

// File: rtl/mem_req_slot.sv
// mem_req_slot
// One pending-request slot for a single arbiter port, plus the port's busy
// flags.
//   clk, resetn          : clock, asynchronous active-low reset
//   addr/wdata/wmask     : port request fields
//   rstrb                : port read strobe
//   clr                  : slot is retired at the end of this cycle
//   cand                 : slot will hold a request after this edge
//                          (the arbitration candidate for this port)
//   slot_addr/wdata/wmask/kind : captured request
//   rbusy, wbusy         : read / write in progress
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  input  logic        clr,
  output logic        cand,
  output logic [31:0] slot_addr,
  output logic [31:0] slot_wdata,
  output logic [3:0]  slot_wmask,
  output req_kind_t   slot_kind,
  output logic        rbusy,
  output logic        wbusy
);

  logic valid;
  logic is_wr;
  logic strobe;
  logic accept;

  // A write mask wins over a simultaneous read strobe.
  assign is_wr  = |wmask;
  assign strobe = is_wr | rstrb;
  // A slot being retired this cycle is free again, so a strobe arriving in
  // the same cycle is taken; this is what allows a write every cycle.
  assign accept = strobe & (~valid | clr);
  assign cand   = (valid & ~clr) | accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid     <= 1'b0;
      slot_kind <= KIND_RD;
    end else begin
      valid <= cand;
      if (accept) slot_kind <= is_wr ? KIND_WR : KIND_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_addr  <= addr;
      slot_wdata <= wdata;
      slot_wmask <= wmask;
    end
  end

  assign rbusy = rstrb | (valid & (slot_kind == KIND_RD));
  assign wbusy = is_wr | (valid & (slot_kind == KIND_WR));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port word RAM (1-cycle registered read) between two
// request ports. Each port owns a request slot; an IDLE/ISSUE/RESP FSM grants
// one slot at a time, drives the RAM command in ISSUE and returns read data
// in RESP. Writes take one cycle, reads two, with no gap between grants.
//   RR     : 1 = round-robin on ties, 0 = fixed priority to port 0
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : request ports and RAM side (mem_arbiter_if.slave)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  bus
);

  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] clr;
  logic [NPORTS-1:0] rd_load;
  logic [NPORTS-1:0] rbusy;
  logic [NPORTS-1:0] wbusy;
  logic [31:0]       s_addr  [NPORTS];
  logic [31:0]       s_wdata [NPORTS];
  logic [3:0]        s_wmask [NPORTS];
  req_kind_t         s_kind  [NPORTS];
  logic [31:0]       rdata_q [NPORTS];

  arb_state_t state, state_nxt;
  logic       grant, grant_nxt;
  logic       last, last_nxt;
  logic       decide;

  mem_req_slot u_slot0 (
    .clk        (clk),
    .resetn     (resetn),
    .addr       (bus.p0_addr),
    .wdata      (bus.p0_wdata),
    .wmask      (bus.p0_wmask),
    .rstrb      (bus.p0_rstrb),
    .clr        (clr[0]),
    .cand       (cand[0]),
    .slot_addr  (s_addr[0]),
    .slot_wdata (s_wdata[0]),
    .slot_wmask (s_wmask[0]),
    .slot_kind  (s_kind[0]),
    .rbusy      (rbusy[0]),
    .wbusy      (wbusy[0])
  );

  mem_req_slot u_slot1 (
    .clk        (clk),
    .resetn     (resetn),
    .addr       (bus.p1_addr),
    .wdata      (bus.p1_wdata),
    .wmask      (bus.p1_wmask),
    .rstrb      (bus.p1_rstrb),
    .clr        (clr[1]),
    .cand       (cand[1]),
    .slot_addr  (s_addr[1]),
    .slot_wdata (s_wdata[1]),
    .slot_wmask (s_wmask[1]),
    .slot_kind  (s_kind[1]),
    .rbusy      (rbusy[1]),
    .wbusy      (wbusy[1])
  );

  // last starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NPORTS; i++) rdata_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (rd_load[i]) rdata_q[i] <= bus.mem_rdata;
      end
    end
  end

  // Slot retirement depends only on the current state, keeping the
  // candidate vector (which depends on clr) free of loops.
  always_comb begin
    clr     = '0;
    rd_load = '0;
    case (state)
      ISSUE: if (s_kind[grant] == KIND_WR) clr[grant] = 1'b1;
      RESP: begin
        clr[grant]     = 1'b1;
        rd_load[grant] = 1'b1;
      end
      default: ;
    endcase
  end

  // The tie pointer only moves on contended decisions, so repeated
  // simultaneous requests alternate even when lone grants intervene.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    decide    = 1'b0;
    case (state)
      IDLE:  decide = 1'b1;
      ISSUE: begin
        if (s_kind[grant] == KIND_WR) decide = 1'b1;
        else state_nxt = RESP;
      end
      RESP:    decide = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (decide) begin
      if (cand == '0) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = ISSUE;
        grant_nxt = pick_port(cand, last, RR != 0);
        if (&cand) last_nxt = grant_nxt;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    if (state == ISSUE) begin
      bus.mem_addr  = s_addr[grant];
      bus.mem_wdata = s_wdata[grant];
      if (s_kind[grant] == KIND_WR) bus.mem_wmask = s_wmask[grant];
      else bus.mem_rstrb = 1'b1;
    end
  end

  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_rdata = rdata_q[1];
  assign bus.p0_rbusy = rbusy[0];
  assign bus.p1_rbusy = rbusy[1];
  assign bus.p0_wbusy = wbusy[0];
  assign bus.p1_wbusy = wbusy[1];

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_arbiter_if bus_rr ();
  mem_arbiter_if bus_fp ();

  mem_arbiter #(.RR(1)) dut_rr (.clk(clk), .resetn(resetn), .bus(bus_rr));
  mem_arbiter #(.RR(0)) dut_fp (.clk(clk), .resetn(resetn), .bus(bus_fp));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h1234_5678;
    if (i == 8) return 32'h1122_3344;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural word RAMs with one-cycle registered read.
  logic [31:0] ram_rr [256];
  logic [31:0] ram_fp [256];
  logic        ram_loaded = 1'b0;
  int          acc_rr = 0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) begin
        ram_rr[i] <= init_word(i);
        ram_fp[i] <= init_word(i);
      end
      bus_rr.mem_rdata <= '0;
      bus_fp.mem_rdata <= '0;
      ram_loaded <= 1'b1;
    end else begin
      if (bus_rr.mem_rstrb) bus_rr.mem_rdata <= ram_rr[bus_rr.mem_addr[9:2]];
      if (|bus_rr.mem_wmask)
        ram_rr[bus_rr.mem_addr[9:2]] <= merge(ram_rr[bus_rr.mem_addr[9:2]],
                                              bus_rr.mem_wdata, bus_rr.mem_wmask);
      if (bus_fp.mem_rstrb) bus_fp.mem_rdata <= ram_fp[bus_fp.mem_addr[9:2]];
      if (|bus_fp.mem_wmask)
        ram_fp[bus_fp.mem_addr[9:2]] <= merge(ram_fp[bus_fp.mem_addr[9:2]],
                                              bus_fp.mem_wdata, bus_fp.mem_wmask);
    end
  end

  always @(posedge clk) begin
    if (bus_rr.mem_rstrb || (bus_rr.mem_wmask != 4'b0)) acc_rr <= acc_rr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_rr(input int port, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic rs);
    if (port == 0) begin
      bus_rr.p0_addr = a; bus_rr.p0_wdata = d; bus_rr.p0_wmask = m; bus_rr.p0_rstrb = rs;
    end else begin
      bus_rr.p1_addr = a; bus_rr.p1_wdata = d; bus_rr.p1_wmask = m; bus_rr.p1_rstrb = rs;
    end
  endtask

  task automatic drv_fp(input int port, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic rs);
    if (port == 0) begin
      bus_fp.p0_addr = a; bus_fp.p0_wdata = d; bus_fp.p0_wmask = m; bus_fp.p0_rstrb = rs;
    end else begin
      bus_fp.p1_addr = a; bus_fp.p1_wdata = d; bus_fp.p1_wmask = m; bus_fp.p1_rstrb = rs;
    end
  endtask

  task automatic idle_rr();
    drv_rr(0, '0, '0, '0, 1'b0);
    drv_rr(1, '0, '0, '0, 1'b0);
  endtask

  task automatic idle_fp();
    drv_fp(0, '0, '0, '0, 1'b0);
    drv_fp(1, '0, '0, '0, 1'b0);
  endtask

  task automatic chk_quiet_rr(input string tag);
    chk({tag, "_mem_rstrb"}, 32'(bus_rr.mem_rstrb), 32'd0);
    chk({tag, "_mem_wmask"}, 32'(bus_rr.mem_wmask), 32'd0);
    chk({tag, "_mem_addr"},  bus_rr.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus_rr.mem_wdata, 32'd0);
    chk({tag, "_p0_rdata"},  bus_rr.p0_rdata, 32'd0);
    chk({tag, "_p1_rdata"},  bus_rr.p1_rdata, 32'd0);
    chk({tag, "_busy"}, {28'd0, bus_rr.p0_rbusy, bus_rr.p0_wbusy,
                         bus_rr.p1_rbusy, bus_rr.p1_wbusy}, 32'd0);
  endtask

  // Random-phase reference state.
  logic [31:0] model_mem [256];
  logic        out_rd [2];
  logic        out_wr [2];
  logic [31:0] pend   [2];
  logic [31:0] last_rd[2];
  int          age    [2];

  logic [31:0] fa [6];
  logic [31:0] fd [6];
  logic [3:0]  fm [6];
  int          snap;
  int          n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_rr();
    idle_fp();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet_rr("reset");
    chk("reset_fp_mem_rstrb", 32'(bus_fp.mem_rstrb), 32'd0);
    resetn = 1'b1;
    tick();

    // Uncontended read latency on port 0.
    drv_rr(0, 32'h10, '0, '0, 1'b1);
    #1 chk("rd_T_rbusy", 32'(bus_rr.p0_rbusy), 32'd1);
    tick(); idle_rr();
    #1 chk("rd_T1_mem_rstrb", 32'(bus_rr.mem_rstrb), 32'd1);
    chk("rd_T1_mem_addr", bus_rr.mem_addr, 32'h10);
    chk("rd_T1_mem_wmask", 32'(bus_rr.mem_wmask), 32'd0);
    tick();
    #1 chk("rd_T2_mem_rstrb", 32'(bus_rr.mem_rstrb), 32'd0);
    chk("rd_T2_rbusy", 32'(bus_rr.p0_rbusy), 32'd1);
    tick();
    #1 chk("rd_T3_rdata", bus_rr.p0_rdata, 32'h1234_5678);
    chk("rd_T3_rbusy", 32'(bus_rr.p0_rbusy), 32'd0);

    // Partial write on port 1, then read back.
    drv_rr(1, 32'h20, 32'hAABB_CCDD, 4'b0011, 1'b0);
    #1 chk("wr_T_wbusy", 32'(bus_rr.p1_wbusy), 32'd1);
    tick(); idle_rr();
    #1 chk("wr_T1_mem_wmask", 32'(bus_rr.mem_wmask), 32'h3);
    chk("wr_T1_mem_addr", bus_rr.mem_addr, 32'h20);
    chk("wr_T1_mem_wdata", bus_rr.mem_wdata, 32'hAABB_CCDD);
    tick();
    #1 chk("wr_T2_wbusy", 32'(bus_rr.p1_wbusy), 32'd0);
    drv_rr(1, 32'h20, '0, '0, 1'b1);
    tick(); idle_rr();
    tick(); tick();
    #1 chk("wr_readback", bus_rr.p1_rdata, 32'h1122_CCDD);

    // Simultaneous reads after reset: port 0 first, then alternate.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    drv_rr(0, 32'h30, '0, '0, 1'b1);
    drv_rr(1, 32'h34, '0, '0, 1'b1);
    tick(); idle_rr();
    tick(); tick();
    #1 chk("tie1_p0_rdata", bus_rr.p0_rdata, init_word(12));
    chk("tie1_p0_rbusy", 32'(bus_rr.p0_rbusy), 32'd0);
    chk("tie1_p1_rbusy", 32'(bus_rr.p1_rbusy), 32'd1);
    tick(); tick();
    #1 chk("tie1_p1_rdata", bus_rr.p1_rdata, init_word(13));
    chk("tie1_p1_rbusy_done", 32'(bus_rr.p1_rbusy), 32'd0);
    drv_rr(0, 32'h38, '0, '0, 1'b1);
    drv_rr(1, 32'h3C, '0, '0, 1'b1);
    tick(); idle_rr();
    tick(); tick();
    #1 chk("tie2_p1_rdata", bus_rr.p1_rdata, init_word(15));
    chk("tie2_p1_rbusy", 32'(bus_rr.p1_rbusy), 32'd0);
    chk("tie2_p0_rbusy", 32'(bus_rr.p0_rbusy), 32'd1);
    tick(); tick();
    #1 chk("tie2_p0_rdata", bus_rr.p0_rdata, init_word(14));

    // A second strobe while the slot is occupied is dropped.
    snap = acc_rr;
    drv_rr(0, 32'h40, '0, '0, 1'b1);
    tick();
    drv_rr(0, 32'h44, '0, '0, 1'b1);
    #1 chk("dup_mem_addr", bus_rr.mem_addr, 32'h40);
    chk("dup_mem_rstrb", 32'(bus_rr.mem_rstrb), 32'd1);
    tick(); idle_rr();
    tick();
    #1 chk("dup_rdata", bus_rr.p0_rdata, init_word(16));
    chk("dup_rbusy", 32'(bus_rr.p0_rbusy), 32'd0);
    tick(); tick();
    chk("dup_access_count", 32'(acc_rr - snap), 32'd1);

    // Reset during RESP aborts the read.
    drv_rr(0, 32'h10, '0, '0, 1'b1);
    tick(); idle_rr();
    tick();
    resetn = 1'b0;
    #1 chk_quiet_rr("rst_resp");
    tick();
    resetn = 1'b1;
    tick();
    drv_rr(0, 32'h10, '0, '0, 1'b1);
    tick(); idle_rr();
    tick(); tick();
    #1 chk("rst_next_rdata", bus_rr.p0_rdata, 32'h1234_5678);
    chk("rst_next_rbusy", 32'(bus_rr.p0_rbusy), 32'd0);

    // Fixed priority: port 0 streams writes while port 1 waits to read.
    for (int k = 0; k < 6; k++) begin
      fa[k] = 32'((32 + k) * 4);
      fd[k] = $urandom;
      fm[k] = 4'($urandom_range(1, 15));
      drv_fp(0, fa[k], fd[k], fm[k], 1'b0);
      if (k == 0) drv_fp(1, 32'h100, '0, '0, 1'b1);
      else drv_fp(1, '0, '0, '0, 1'b0);
      #1 chk("fp_p1_rbusy_stream", 32'(bus_fp.p1_rbusy), 32'd1);
      if (k > 0) begin
        chk("fp_stream_wmask", 32'(bus_fp.mem_wmask), 32'(fm[k-1]));
        chk("fp_stream_addr", bus_fp.mem_addr, fa[k-1]);
      end
      tick();
    end
    idle_fp();
    #1 chk("fp_last_wmask", 32'(bus_fp.mem_wmask), 32'(fm[5]));
    n = 0;
    while (bus_fp.p1_rbusy && n < 8) begin
      tick();
      n++;
    end
    chk("fp_p1_done_cycles", 32'(n), 32'd3);
    chk("fp_p1_rdata", bus_fp.p1_rdata, init_word(64));
    for (int k = 0; k < 6; k++)
      chk("fp_ram_word", ram_fp[32 + k], merge(init_word(32 + k), fd[k], fm[k]));

    // Randomised traffic on the round-robin arbiter; port 0 uses words
    // 64..95 and port 1 words 96..127, each port waiting for its own
    // previous request to finish.
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    last_rd[0] = 32'h1234_5678;
    last_rd[1] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      out_rd[p] = 1'b0; out_wr[p] = 1'b0; age[p] = 0; pend[p] = '0;
    end
    tick();
    for (int cyc = 0; cyc < 440; cyc++) begin
      logic        rb, wb;
      logic [31:0] rd;
      idle_rr();
      #1;
      for (int p = 0; p < 2; p++) begin
        rb = (p == 0) ? bus_rr.p0_rbusy : bus_rr.p1_rbusy;
        wb = (p == 0) ? bus_rr.p0_wbusy : bus_rr.p1_wbusy;
        rd = (p == 0) ? bus_rr.p0_rdata : bus_rr.p1_rdata;
        if (out_rd[p] && !rb) begin
          last_rd[p] = pend[p];
          out_rd[p] = 1'b0;
        end
        if (out_wr[p] && !wb) out_wr[p] = 1'b0;
        chk("rnd_rdata", rd, last_rd[p]);
        if (out_rd[p] || out_wr[p]) begin
          age[p]++;
          if (age[p] > 12) begin
            chk("rnd_timeout", 32'(age[p]), 32'd12);
            out_rd[p] = 1'b0;
            out_wr[p] = 1'b0;
          end
        end else begin
          chk("rnd_idle_busy", {30'd0, rb, wb}, 32'd0);
          if (cyc < 400 && $urandom_range(0, 1) == 1) begin
            int          idx, op;
            logic [31:0] d;
            logic [3:0]  m;
            idx = 64 + 32 * p + int'($urandom_range(0, 31));
            op  = int'($urandom_range(0, 2));
            d   = $urandom;
            m   = 4'($urandom_range(1, 15));
            age[p] = 0;
            if (op == 0) begin
              drv_rr(p, 32'(idx * 4), d, 4'b0, 1'b1);
              pend[p] = model_mem[idx];
              out_rd[p] = 1'b1;
            end else begin
              drv_rr(p, 32'(idx * 4), d, m, op == 2);
              model_mem[idx] = merge(model_mem[idx], d, m);
              out_wr[p] = 1'b1;
            end
          end
        end
      end
      tick();
    end
    idle_rr();
    for (int i = 64; i < 128; i++) chk("rnd_ram_word", ram_rr[i], model_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
